// File: rtl/alu_pkg.sv
// Shared types and widths for the 4-bit ALU and its request arbiter.
package alu_pkg;

    localparam int OPW = 4;   // opcode width
    localparam int DW  = 4;   // operand width
    localparam int RW  = 8;   // result width

    // Opcodes 13..15 are not defined and report an error.
    typedef enum logic [OPW-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NAND = 4'd7,
        OP_NOR  = 4'd8,
        OP_NOT  = 4'd9,
        OP_MOD  = 4'd10,
        OP_SHL  = 4'd11,
        OP_SHR  = 4'd12
    } op_t;

    // Arbiter sequencing: accept in IDLE, compute in EXEC, hold result in RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bus bundle between two requesters / one consumer and the ALU arbiter.
//
// Handshake rule for every channel here: a transfer happens on a rising
// clock edge where valid and ready are both high. A source that raised
// valid keeps valid and its payload stable until that transfer; ready may
// depend combinationally on valid.
interface alu_req_arbiter_if;
    import alu_pkg::*;

    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [DW-1:0]  req0_x;
    logic [DW-1:0]  req0_y;

    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [DW-1:0]  req1_x;
    logic [DW-1:0]  req1_y;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [RW-1:0]  rsp_result;
    logic           rsp_err;

    logic           busy;
    state_t         dbg_state;

    // Requesters plus result consumer.
    modport master (
        output req0_valid, req0_op, req0_x, req0_y,
        output req1_valid, req1_op, req1_x, req1_y,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_err,
        input  busy, dbg_state
    );

    // The arbiter itself.
    modport slave (
        input  req0_valid, req0_op, req0_x, req0_y,
        input  req1_valid, req1_op, req1_x, req1_y,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_err,
        output busy, dbg_state
    );

endinterface

// File: rtl/alu_core_4b.sv
// Purely combinational 4-bit ALU: (op, x, y) -> 8-bit result plus error flag.
// Shared with the standalone ALU top, so it carries no clock or state.
module alu_core_4b
    import alu_pkg::*;
(
    input  logic [OPW-1:0] i_op,
    input  logic [DW-1:0]  i_x,
    input  logic [DW-1:0]  i_y,
    output logic [RW-1:0]  o_result,
    output logic           o_err
);

    logic [RW-1:0] w_x_u;   // zero-extended operands
    logic [RW-1:0] w_y_u;
    logic [RW-1:0] w_x_s;   // sign-extended operands for SUB
    logic [RW-1:0] w_y_s;
    logic          w_y_zero;

    assign w_x_u    = {4'b0000, i_x};
    assign w_y_u    = {4'b0000, i_y};
    assign w_x_s    = {{4{i_x[DW-1]}}, i_x};
    assign w_y_s    = {{4{i_y[DW-1]}}, i_y};
    assign w_y_zero = (i_y == '0);

    // Opcode decode; undefined opcodes and divide-by-zero give 0 with err set.
    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (i_op)
            OP_ADD:  o_result = w_x_u + w_y_u;
            OP_SUB:  o_result = w_x_s - w_y_s;
            OP_MUL:  o_result = w_x_u * w_y_u;
            OP_DIV: begin
                if (w_y_zero) o_err    = 1'b1;
                else          o_result = {4'b0000, i_x / i_y};
            end
            OP_AND:  o_result = {4'b0000, i_x & i_y};
            OP_OR:   o_result = {4'b0000, i_x | i_y};
            OP_XOR:  o_result = {4'b0000, i_x ^ i_y};
            OP_NAND: o_result = {4'b0000, ~(i_x & i_y)};
            OP_NOR:  o_result = {4'b0000, ~(i_x | i_y)};
            OP_NOT:  o_result = ~{i_y, i_x};
            OP_MOD: begin
                if (w_y_zero) o_err    = 1'b1;
                else          o_result = {4'b0000, i_x % i_y};
            end
            OP_SHL:  o_result = w_x_u << i_y;
            OP_SHR:  o_result = {4'b0000, i_x >> i_y};
            default: o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-requester front end for the 4-bit ALU. One op in flight at a time:
// IDLE accepts a request, EXEC registers the ALU output, RESP holds the
// tagged result until the consumer takes it.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 always
// wins a conflict). Without it, conflicts are settled round-robin starting
// from ARB_PRIO_DEFAULT after reset.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter logic ARB_PRIO_DEFAULT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    alu_req_arbiter_if.slave  bus
);

    state_t         r_state;
    logic [OPW-1:0] r_op;
    logic [DW-1:0]  r_x;
    logic [DW-1:0]  r_y;
    logic           r_id;
    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic [RW-1:0]  r_rsp_result;
    logic           r_rsp_err;
    logic           r_busy;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic           r_rr_ptr;    // owner of the next conflict
`endif

    logic           w_idle;
    logic           w_win_id;
    logic           w_accept;
    logic [OPW-1:0] w_win_op;
    logic [DW-1:0]  w_win_x;
    logic [DW-1:0]  w_win_y;
    logic [RW-1:0]  w_alu_result;
    logic           w_alu_err;

    assign w_idle = (r_state == IDLE);

    // Pick the requester to serve; only meaningful while at least one is valid.
    always_comb begin
        w_win_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w_win_id = 1'b0;
`else
            w_win_id = r_rr_ptr;
`endif
        end else if (bus.req1_valid) begin
            w_win_id = 1'b1;
        end
    end

    assign w_accept       = w_idle && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = w_idle && bus.req0_valid && !w_win_id;
    assign bus.req1_ready = w_idle && bus.req1_valid &&  w_win_id;

    assign w_win_op = w_win_id ? bus.req1_op : bus.req0_op;
    assign w_win_x  = w_win_id ? bus.req1_x  : bus.req0_x;
    assign w_win_y  = w_win_id ? bus.req1_y  : bus.req0_y;

    alu_core_4b u_core (
        .i_op     (r_op),
        .i_x      (r_x),
        .i_y      (r_y),
        .o_result (w_alu_result),
        .o_err    (w_alu_err)
    );

    // Sequencer: latches the winner, registers the ALU result, holds it until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_op         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_rr_ptr     <= ARB_PRIO_DEFAULT;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_win_op;
                        r_x     <= w_win_x;
                        r_y     <= w_win_y;
                        r_id    <= w_win_id;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        // Hand the next conflict to the requester just passed over.
                        r_rr_ptr <= ~w_win_id;
`endif
                    end
                end
                EXEC: begin
                    r_rsp_result <= w_alu_result;
                    r_rsp_err    <= w_alu_err;
                    r_rsp_id     <= r_id;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = r_busy;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: reset values, per-opcode results,
// latency, arbitration order, back-pressure and mid-operation reset.
module tb_alu_req_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_req_arbiter_if bus ();

    alu_req_arbiter #(.ARB_PRIO_DEFAULT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and run limit.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "run limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic id, input logic v, input logic [3:0] op,
                         input logic [3:0] x, input logic [3:0] y);
        if (id == 1'b0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_x = x; bus.req0_y = y;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_x = x; bus.req1_y = y;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".rsp_valid"},  8'(bus.rsp_valid),  8'h00);
        check({tag, ".rsp_id"},     8'(bus.rsp_id),     8'h00);
        check({tag, ".rsp_result"}, bus.rsp_result,     8'h00);
        check({tag, ".rsp_err"},    8'(bus.rsp_err),    8'h00);
        check({tag, ".ready0"},     8'(bus.req0_ready), 8'h00);
        check({tag, ".ready1"},     8'(bus.req1_ready), 8'h00);
        check({tag, ".busy"},       8'(bus.busy),       8'h00);
        check({tag, ".state"},      8'(bus.dbg_state),  8'(IDLE));
    endtask

    // Issue one op from a single requester with rsp_ready high and check timing and result.
    task automatic single_op(input string tag, input logic id, input logic [3:0] op,
                             input logic [3:0] x, input logic [3:0] y,
                             input logic [7:0] exp_res, input logic exp_err);
        drive(id, 1'b1, op, x, y);
        #1;
        check({tag, ".rdy_win"},  8'(id ? bus.req1_ready : bus.req0_ready), 8'h01);
        check({tag, ".rdy_lose"}, 8'(id ? bus.req0_ready : bus.req1_ready), 8'h00);
        tick();
        drive(id, 1'b0, 4'h0, 4'h0, 4'h0);
        check({tag, ".exec_valid"}, 8'(bus.rsp_valid), 8'h00);
        check({tag, ".exec_busy"},  8'(bus.busy),      8'h01);
        tick();
        check({tag, ".valid"},  8'(bus.rsp_valid), 8'h01);
        check({tag, ".id"},     8'(bus.rsp_id),    8'(id));
        check({tag, ".result"}, bus.rsp_result,    exp_res);
        check({tag, ".err"},    8'(bus.rsp_err),   8'(exp_err));
        tick();
        check({tag, ".done_valid"}, 8'(bus.rsp_valid), 8'h00);
        check({tag, ".done_busy"},  8'(bus.busy),      8'h00);
    endtask

    initial begin
        logic exp_id;

        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        bus.rsp_ready = 1'b1;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;

        // Single-requester ops with hand-computed results.
        single_op("add_9_7",   1'b0, 4'd0,  4'd9,  4'd7,  8'h10, 1'b0);
        single_op("sub_2_m5",  1'b1, 4'd1,  4'd2,  4'hB,  8'h07, 1'b0);
        single_op("sub_m8_1",  1'b1, 4'd1,  4'd8,  4'd1,  8'hF7, 1'b0);
        single_op("div_6_0",   1'b0, 4'd3,  4'd6,  4'd0,  8'h00, 1'b1);
        single_op("op14",      1'b1, 4'd14, 4'd5,  4'd3,  8'h00, 1'b1);
        single_op("shl_15_5",  1'b0, 4'd11, 4'd15, 4'd5,  8'hE0, 1'b0);
        single_op("mul_15_15", 1'b1, 4'd2,  4'd15, 4'd15, 8'hE1, 1'b0);
        single_op("div_13_4",  1'b0, 4'd3,  4'd13, 4'd4,  8'h03, 1'b0);
        single_op("mod_13_4",  1'b1, 4'd10, 4'd13, 4'd4,  8'h01, 1'b0);
        single_op("mod_7_0",   1'b0, 4'd10, 4'd7,  4'd0,  8'h00, 1'b1);
        single_op("not_3_5",   1'b0, 4'd9,  4'd3,  4'd5,  8'hAC, 1'b0);
        single_op("nand_c_a",  1'b1, 4'd7,  4'hC,  4'hA,  8'h07, 1'b0);
        single_op("nor_c_a",   1'b0, 4'd8,  4'hC,  4'hA,  8'h01, 1'b0);
        single_op("shr_12_2",  1'b1, 4'd12, 4'd12, 4'd2,  8'h03, 1'b0);
        single_op("op15",      1'b0, 4'd15, 4'd1,  4'd1,  8'h00, 1'b1);

        // Both requesters valid continuously from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b1, 4'd0, 4'd1, 4'd1);   // req0: 1+1 = 2
        drive(1'b1, 1'b1, 4'd0, 4'd2, 4'd2);   // req1: 2+2 = 4
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = i[0];
`endif
            check($sformatf("rr%0d.ready0", i), 8'(bus.req0_ready), 8'(!exp_id));
            check($sformatf("rr%0d.ready1", i), 8'(bus.req1_ready), 8'(exp_id));
            tick();
            check($sformatf("rr%0d.exec_rdy", i), 8'({bus.req0_ready, bus.req1_ready}), 8'h00);
            tick();
            check($sformatf("rr%0d.valid", i),  8'(bus.rsp_valid), 8'h01);
            check($sformatf("rr%0d.id", i),     8'(bus.rsp_id),    8'(exp_id));
            check($sformatf("rr%0d.result", i), bus.rsp_result,    exp_id ? 8'h04 : 8'h02);
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        tick();

        // Back-pressure: consumer stalls while a second request waits.
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 4'd6, 4'hC, 4'hA);   // XOR = 6
        tick();
        drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        drive(1'b0, 1'b1, 4'd5, 4'd3, 4'd4);   // OR = 7, waits
        tick();
        check("bp.valid", 8'(bus.rsp_valid), 8'h01);
        check("bp.result", bus.rsp_result, 8'h06);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d.valid", i),  8'(bus.rsp_valid),  8'h01);
            check($sformatf("hold%0d.id", i),     8'(bus.rsp_id),     8'h01);
            check($sformatf("hold%0d.result", i), bus.rsp_result,     8'h06);
            check($sformatf("hold%0d.err", i),    8'(bus.rsp_err),    8'h00);
            check($sformatf("hold%0d.busy", i),   8'(bus.busy),       8'h01);
            check($sformatf("hold%0d.ready0", i), 8'(bus.req0_ready), 8'h00);
            check($sformatf("hold%0d.ready1", i), 8'(bus.req1_ready), 8'h00);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("release.valid",  8'(bus.rsp_valid),  8'h00);
        check("release.busy",   8'(bus.busy),       8'h00);
        check("release.state",  8'(bus.dbg_state),  8'(IDLE));
        check("release.ready0", 8'(bus.req0_ready), 8'h01);

        // Reset while the waiting op is in EXEC: it must vanish.
        tick();
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        check("midrst.state", 8'(bus.dbg_state), 8'(EXEC));
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("post.valid", 8'(bus.rsp_valid), 8'h00);
        check("post.busy",  8'(bus.busy),      8'h00);

        // Normal service resumes after the reset.
        single_op("after_rst_or", 1'b0, 4'd5, 4'd3, 4'd4, 8'h07, 1'b0);
        single_op("after_rst_and", 1'b1, 4'd4, 4'hC, 4'hA, 8'h08, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
